// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the left-justified audio DAC transmitter.
package audio_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned CHAN_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider and frame bit counter; produces BCLK, LRCK and the falling-edge strobes.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic start,
    output logic bclk,
    output logic lrck,
    output logic fall_strobe,
    output logic frame_strobe
);

    localparam int unsigned DIV_W = $clog2(BCLK_HALF);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] CHAN_LIM = BIT_W'(CHAN_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;

    // Strobes flag the edge at which BCLK drops, so every consumer updates on that same edge.
    assign fall_strobe  = bclk && (div_cnt == DIV_LAST);
    assign frame_strobe = fall_strobe && (bit_cnt == BIT_LAST);
    assign bit_nxt      = bit_cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset || clear) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else if (start) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b1;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_strobe) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt < CHAN_LIM);
            end
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Left-justified mono-to-stereo DAC transmitter: holding register, frame shifter and run/drain control.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned UCNT_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [15:0]       sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sample_tick,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT
);

    i2s_state_t state, state_nxt;

    logic                  load, start, clear;
    logic                  fall_strobe, frame_strobe;
    logic                  full;
    logic [CHAN_BITS-1:0]  hold, last, s_frame;
    logic [FRAME_BITS-1:0] sr;
    logic                  xfer;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
        .Clk          (Clk),
        .Reset        (Reset),
        .clear        (clear),
        .start        (start),
        .bclk         (AUD_BCLK),
        .lrck         (AUD_DACLRCK),
        .fall_strobe  (fall_strobe),
        .frame_strobe (frame_strobe)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // The first frame is loaded on the IDLE->RUN edge so its tick lands in the first RUN cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (Enable) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                    load      = 1'b1;
                end else begin
                    clear = 1'b1;
                end
            end
            RUN: begin
                load = frame_strobe;
                if (!Enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (Enable) begin
                    state_nxt = RUN;
                    load      = frame_strobe;
                end else if (frame_strobe) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sample_ready = !full;
    assign xfer         = sample_valid && !full;
    assign s_frame      = full ? hold : last;
    assign AUD_DACDAT   = sr[FRAME_BITS-1];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            full         <= 1'b0;
            hold         <= '0;
            last         <= '0;
            sr           <= '0;
            sample_tick  <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            sample_tick <= load;
            if (load) begin
                sr   <= {s_frame, s_frame};
                last <= s_frame;
                if (!full && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
            end else if (clear) begin
                sr <= '0;
            end else if (fall_strobe) begin
                sr <= {sr[FRAME_BITS-2:0], 1'b0};
            end
            // A load while empty reads the old (empty) contents even if a transfer lands now.
            if (load && full) begin
                full <= 1'b0;
            end else if (xfer) begin
                full <= 1'b1;
                hold <= sample_in;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: default divider instance plus a BCLK_HALF=2 / UCNT_W=2 instance.
module tb_audio_i2s_tx;

    logic        Clk = 1'b0;
    logic        Reset, Enable, sample_valid;
    logic [15:0] sample_in;
    logic        sel;

    logic       ready1, tick1, bclk1, lrck1, dat1;
    logic [7:0] ucnt1;
    logic       ready2, tick2, bclk2, lrck2, dat2;
    logic [1:0] ucnt2;

    logic       ready, tick, bclk, lrck, dat;
    logic [7:0] ucnt;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    audio_i2s_tx #(.BCLK_HALF(16), .UCNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(ready1), .sample_tick(tick1),
        .underrun_cnt(ucnt1), .AUD_BCLK(bclk1), .AUD_DACLRCK(lrck1), .AUD_DACDAT(dat1)
    );

    audio_i2s_tx #(.BCLK_HALF(2), .UCNT_W(2)) dut_fast (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(ready2), .sample_tick(tick2),
        .underrun_cnt(ucnt2), .AUD_BCLK(bclk2), .AUD_DACLRCK(lrck2), .AUD_DACDAT(dat2)
    );

    always_comb begin
        ready = sel ? ready2 : ready1;
        tick  = sel ? tick2  : tick1;
        bclk  = sel ? bclk2  : bclk1;
        lrck  = sel ? lrck2  : lrck1;
        dat   = sel ? dat2   : dat1;
        ucnt  = sel ? {6'd0, ucnt2} : ucnt1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_tick(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 1200) begin
            step();
            cyc++;
            if (tick) ok = 1'b1;
        end
    endtask

    // Collects DACDAT/LRCK on the next 32 BCLK rising edges; optionally drops Enable after bit drop_at.
    task automatic capture(input int drop_at, output logic [31:0] data, output logic [31:0] lr,
                           output int cyc, output int period);
        int   nb    = 0;
        int   first = 0;
        logic prev;
        data   = '0;
        lr     = '0;
        cyc    = 0;
        period = 0;
        prev   = bclk;
        while (nb < 32 && cyc < 1200) begin
            step();
            cyc++;
            if (bclk && !prev) begin
                data = {data[30:0], dat};
                lr   = {lr[30:0], lrck};
                if (nb == 0) first = cyc;
                else if (nb == 1) period = cyc - first;
                if (nb == drop_at) Enable = 1'b0;
                nb++;
            end
            prev = bclk;
        end
    endtask

    task automatic push(input logic [15:0] v, output bit ok);
        ok           = 1'b0;
        sample_in    = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 1200 && !ok; i++) begin
            if (ready) ok = 1'b1;
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset        = 1'b0;
        Enable       = 1'b0;
        sample_valid = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bit ok;
        int nb = 0;
        logic prev;
        push(16'hFFFF, ok);
        Enable = 1'b1;
        step();
        push(16'h5555, ok);
        prev = bclk;
        for (int i = 0; i < 1200 && nb < 11; i++) begin
            step();
            if (bclk && !prev) nb++;
            prev = bclk;
        end
        Reset  = 1'b0;
        Enable = 1'b0;
        step();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b expected 0", bclk); end
        checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL reset_lrck: got %b expected 0", lrck); end
        checks++; if (dat !== 1'b0) begin errors++; $display("FAIL reset_dat: got %b expected 0", dat); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        checks++; if (ucnt !== 8'd0) begin errors++; $display("FAIL reset_ucnt: got %0d expected 0", ucnt); end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_first_frame();
        bit ok;
        logic [31:0] data, lr;
        int cyc, per, w;
        push(16'h8001, ok);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL first_full: got ready %b expected 0", ready); end
        Enable = 1'b1;
        step();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b expected 1", tick); end
        checks++; if (lrck !== 1'b1 || dat !== 1'b1) begin errors++;
            $display("FAIL first_load: got lrck %b dat %b expected 1 1", lrck, dat); end
        checks++; if (ucnt !== 8'd0) begin errors++; $display("FAIL first_ucnt: got %0d expected 0", ucnt); end
        capture(-1, data, lr, cyc, per);
        checks++; if (data !== 32'h80018001) begin errors++; $display("FAIL first_data: got %h expected 80018001", data); end
        checks++; if (lr !== 32'hFFFF0000) begin errors++; $display("FAIL first_lrck: got %h expected ffff0000", lr); end
        checks++; if (per !== 32) begin errors++; $display("FAIL first_bclk_period: got %0d expected 32", per); end
        wait_tick(w, ok);
        checks++; if (!ok || (cyc + w) !== 1024) begin errors++;
            $display("FAIL first_frame_len: got %0d expected 1024", cyc + w); end
        checks++; if (ucnt !== 8'd1) begin errors++; $display("FAIL first_underrun: got %0d expected 1", ucnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] data, lr;
        int cyc, per, w;
        logic tick_at_ready = 1'b0;
        push(16'h1234, ok);
        checks++; if (!ok || ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got ready %b expected 0", ready); end
        sample_in    = 16'hABCD;
        sample_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            step();
            if (ready) begin
                ok            = 1'b1;
                tick_at_ready = tick;
            end
        end
        checks++; if (!ok || tick_at_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_ready_at_tick: got tick %b expected 1", tick_at_ready); end
        step();
        sample_valid = 1'b0;
        capture(-1, data, lr, cyc, per);
        checks++; if (data !== 32'h12341234) begin errors++; $display("FAIL b2b_first: got %h expected 12341234", data); end
        wait_tick(w, ok);
        capture(-1, data, lr, cyc, per);
        checks++; if (data !== 32'hABCDABCD) begin errors++; $display("FAIL b2b_second: got %h expected abcdabcd", data); end
        checks++; if (ucnt !== 8'd1) begin errors++; $display("FAIL b2b_ucnt: got %0d expected 1", ucnt); end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [31:0] data, lr;
        int cyc, per, w;
        pulse_reset();
        push(16'h7FFF, ok);
        Enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_tick(w, ok);
            checks++; if (ucnt !== 8'(i)) begin errors++; $display("FAIL underrun_cnt%0d: got %0d expected %0d", i, ucnt, i); end
            capture(-1, data, lr, cyc, per);
            checks++; if (data !== 32'h7FFF7FFF) begin errors++;
                $display("FAIL underrun_data%0d: got %h expected 7fff7fff", i, data); end
        end
    endtask

    task automatic test_drain();
        bit ok;
        logic [31:0] data, lr;
        int cyc, per, w;
        int ticks = 0;
        int active = 0;
        wait_tick(w, ok);
        checks++; if (!ok || ucnt !== 8'd4) begin errors++; $display("FAIL drain_ucnt: got %0d expected 4", ucnt); end
        capture(5, data, lr, cyc, per);
        checks++; if (data !== 32'h7FFF7FFF || lr !== 32'hFFFF0000) begin errors++;
            $display("FAIL drain_frame: got %h/%h expected 7fff7fff/ffff0000", data, lr); end
        for (int i = 0; i < 2100; i++) begin
            step();
            if (tick) ticks++;
            if (i >= 20 && (bclk || lrck || dat)) active++;
        end
        checks++; if (ticks !== 0) begin errors++; $display("FAIL drain_ticks: got %0d expected 0", ticks); end
        checks++; if (active !== 0) begin errors++; $display("FAIL drain_idle_outputs: got %0d active cycles expected 0", active); end
        Enable = 1'b1;
        step();
        checks++; if (tick !== 1'b1 || lrck !== 1'b1) begin errors++;
            $display("FAIL drain_reenable: got tick %b lrck %b expected 1 1", tick, lrck); end
    endtask

    task automatic test_fast();
        bit ok;
        logic [31:0] data, lr;
        int cyc, per, w;
        sel = 1'b1;
        pulse_reset();
        push(16'h8001, ok);
        Enable = 1'b1;
        step();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL fast_tick: got %b expected 1", tick); end
        capture(-1, data, lr, cyc, per);
        checks++; if (data !== 32'h80018001 || lr !== 32'hFFFF0000) begin errors++;
            $display("FAIL fast_data: got %h/%h expected 80018001/ffff0000", data, lr); end
        checks++; if (per !== 4) begin errors++; $display("FAIL fast_bclk_period: got %0d expected 4", per); end
        wait_tick(w, ok);
        checks++; if (!ok || (cyc + w) !== 128) begin errors++;
            $display("FAIL fast_frame_len: got %0d expected 128", cyc + w); end
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) wait_tick(w, ok);
            checks++; if (ucnt !== 8'(i > 3 ? 3 : i)) begin errors++;
                $display("FAIL fast_ucnt%0d: got %0d expected %0d", i, ucnt, (i > 3 ? 3 : i)); end
            capture(-1, data, lr, cyc, per);
            checks++; if (data !== 32'h80018001) begin errors++;
                $display("FAIL fast_repeat%0d: got %h expected 80018001", i, data); end
        end
    endtask

    initial begin
        sel          = 1'b0;
        sample_in    = '0;
        Reset        = 1'b0;
        Enable       = 1'b0;
        sample_valid = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_underrun();
        test_drain();
        test_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter that sits directly downstream of the biquad filter stage. It takes the filter's 16-bit signed mono output and drives the audio codec's DAC port in left-justified format as bus master, duplicating the sample onto left and right. It generates BCLK and DACLRCK from the system clock. Once per frame it pulses a sample tick, which paces the synth/filter chain.

## Interface
- BCLK_HALF, 16: Clk cycles per BCLK half-period; must be ≥2. At Clk = 50 MHz: BCLK 1.5625 MHz, fs 48.83 kHz.
- UCNT_W, 8: width of the underrun counter.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low (0 = reset).
- Enable  in  1  run request.
- sample_in  in  16  signed sample from the filter's y output.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  holding register empty; a transfer occurs when valid && ready.
- sample_tick  out  1  one-Clk pulse on each frame load.
- underrun_cnt  out  UCNT_W  frames sent without a fresh sample; saturating.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  1 = left channel, 0 = right channel.
- AUD_DACDAT  out  1  serial data, MSB first.

## Operation
- States:
  - IDLE: BCLK, LRCK and DACDAT held 0; counters cleared.
  - RUN: free-running frames.
  - DRAIN: finish the current frame, then go to IDLE.
- Transitions:
  - IDLE→RUN when Enable = 1. The first frame loads in the first RUN cycle.
  - RUN→DRAIN when Enable = 0.
  - DRAIN→RUN if Enable returns to 1 before the frame ends. Otherwise DRAIN→IDLE at the frame-end falling edge; no new load occurs.
- Holding register: 16 bits plus a full flag. sample_ready = !full.
  - An accepted transfer sets full and stores sample_in. Accepting is legal in any state.
- Frame load (start of each frame): the 32-bit shift register is loaded with {S, S}.
  - S = the held sample if full; full is then cleared.
  - If not full, S = the last transmitted sample (0 after reset), and underrun_cnt increments, saturating at all-ones.
  - sample_tick = 1 for that Clk cycle.
- If a transfer and a frame load happen in the same cycle, the load uses the old contents. This cannot occur while full, because ready is low.
- Reset (Reset = 0) takes priority over everything, including mid-frame. All outputs return to their reset values in the next cycle.

## Timing
- Reset values: state IDLE, AUD_BCLK 0, AUD_DACLRCK 0, AUD_DACDAT 0, sample_ready 1, sample_tick 0, underrun_cnt 0, held sample 0, last sample 0.
- Divider counter runs 0..BCLK_HALF-1. BCLK toggles in the cycle after the counter reaches BCLK_HALF-1.
- Bit counter runs 0..31 and advances on each BCLK falling edge.
  - AUD_DACLRCK = 1 for bits 0–15, 0 for bits 16–31.
  - AUD_DACDAT = shift-register MSB; it changes only on BCLK falling edges (or at load), so it is stable on BCLK rising edges.
- Frame load occurs in the cycle BCLK falls while the bit counter wraps 31→0, and also in the first RUN cycle. In that same cycle LRCK goes to 1 and DACDAT = S[15].
- Frame length: 64·BCLK_HALF Clk cycles, i.e. 1024 with the default. sample_tick period equals the frame length.
- Latency: a sample accepted at cycle t appears on DACDAT at the next frame load.

## Structure
- Package audio_pkg holds:
  - FRAME_BITS = 32 and CHAN_BITS = 16.
  - the i2s_state_t enum {IDLE, RUN, DRAIN}.
- One sub-module, i2s_bclk_gen. It contains the divider and bit counter and outputs BCLK, LRCK, fall_strobe and frame_strobe.
- The top level contains the FSM, holding register, shift register and underrun counter.

## Test plan
- Reset mid-frame (Reset = 0 at bit 10) -> next cycle: BCLK = LRCK = DACDAT = 0, ready = 1, underrun_cnt = 0.
- Enable = 1, push 16'h8001 before the first tick -> the first frame streams 1000…0001 on both the LRCK = 1 and LRCK = 0 halves. The checker samples on BCLK rising edges, 32 bits per 1024 Clk cycles.
- Push 16'h1234, then 16'hABCD while full -> ready stays low until the next tick. The frames carry 1234 then ABCD, with no loss.
- No samples after 16'h7FFF -> 7FFF repeats and underrun_cnt counts 1, 2, 3… With UCNT_W = 2 it saturates at 3.
- Drop Enable at bit 5 -> the frame completes all 32 bits, then IDLE, with no further sample_tick. Re-enable -> a tick occurs in the first RUN cycle.
- BCLK_HALF = 2 -> BCLK period is 4 Clk cycles and the frame is 128 cycles; the data checks above still pass.
